// File: rtl/serial_bit_source.sv
// Parallel-to-serial word source feeding the sequence detector's serial input.
// One-word hold buffer behind a valid/ready handshake lets words stream back-to-back.
module serial_bit_source #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0,
   parameter int GAP       = 0
) (
   input  logic             clock,
   input  logic             Resetn,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             last,
   output logic             busy
);

   // state    | meaning
   // ST_IDLE  | nothing streaming; waits for the hold buffer to fill
   // ST_SHIFT | one word bit per cycle on sout, cnt = index of the current bit
   // ST_GAP   | idle cycles between words, gcnt = index of the current gap cycle

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
   localparam logic [3:0]    GCNT_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] sh_nxt;
   logic [WIDTH-1:0] hold;
   logic             hold_full;
   logic             hold_full_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [3:0]       gcnt;
   logic [3:0]       gcnt_nxt;
   logic             accept;
   logic             reload;
   logic             sout_nxt;
   logic             sout_valid_nxt;
   logic             last_nxt;

   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
      if (MSB_FIRST) shift_once = {s[WIDTH-2:0], IDLE_BIT};
      else           shift_once = {IDLE_BIT, s[WIDTH-1:1]};
   endfunction

   function automatic logic head_bit(input logic [WIDTH-1:0] s);
      if (MSB_FIRST) head_bit = s[WIDTH-1];
      else           head_bit = s[0];
   endfunction

   // Ready depends only on the hold flag so the producer never sees a combinational loop.
   assign din_ready = !hold_full;
   assign accept    = din_valid && !hold_full;
   assign busy      = (state != ST_IDLE) || hold_full;

   always_comb begin
      state_nxt = state;
      sh_nxt    = sh;
      cnt_nxt   = cnt;
      gcnt_nxt  = gcnt;
      reload    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (hold_full) reload = 1'b1;
         end
         ST_SHIFT: begin
            sh_nxt = shift_once(sh);
            if (cnt == CNT_LAST) begin
               cnt_nxt = '0;
               if (GAP > 0) begin
                  state_nxt = ST_GAP;
                  gcnt_nxt  = 4'd0;
               end else if (hold_full) begin
                  reload = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_GAP: begin
            if (gcnt == GCNT_LAST) begin
               gcnt_nxt = 4'd0;
               if (hold_full) reload = 1'b1;
               else           state_nxt = ST_IDLE;
            end else begin
               gcnt_nxt = gcnt + 4'd1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (reload) begin
         sh_nxt    = hold;
         cnt_nxt   = '0;
         state_nxt = ST_SHIFT;
      end

      // Reload and accept are exclusive: accept needs the hold empty, reload needs it full.
      hold_full_nxt  = (hold_full && !reload) || accept;

      sout_valid_nxt = (state_nxt == ST_SHIFT);
      sout_nxt       = sout_valid_nxt ? head_bit(sh_nxt) : IDLE_BIT;
      last_nxt       = sout_valid_nxt && (cnt_nxt == CNT_LAST);
   end

   always_ff @(posedge clock) begin
      if (Resetn) begin
         state      <= ST_IDLE;
         sh         <= {WIDTH{IDLE_BIT}};
         hold       <= '0;
         hold_full  <= 1'b0;
         cnt        <= '0;
         gcnt       <= 4'd0;
         sout       <= IDLE_BIT;
         sout_valid <= 1'b0;
         last       <= 1'b0;
      end else begin
         state      <= state_nxt;
         sh         <= sh_nxt;
         hold_full  <= hold_full_nxt;
         cnt        <= cnt_nxt;
         gcnt       <= gcnt_nxt;
         sout       <= sout_nxt;
         sout_valid <= sout_valid_nxt;
         last       <= last_nxt;
         if (accept) hold <= din;
      end
   end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: three instances (GAP=0 MSB-first, GAP=2 MSB-first,
// GAP=0 LSB-first) checked every cycle against a word/queue reference model.
module tb_serial_bit_source;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         rst;
   logic [W-1:0] din [3];
   logic         dv  [3];
   logic [2:0]   rdy, so, sv, lst, bsy;

   always #5 clock = ~clock;

   serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(0)) dut0 (
      .clock(clock), .Resetn(rst), .din(din[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
      .sout(so[0]), .sout_valid(sv[0]), .last(lst[0]), .busy(bsy[0]));
   serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(2)) dut1 (
      .clock(clock), .Resetn(rst), .din(din[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
      .sout(so[1]), .sout_valid(sv[1]), .last(lst[1]), .busy(bsy[1]));
   serial_bit_source #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .GAP(0)) dut2 (
      .clock(clock), .Resetn(rst), .din(din[2]), .din_valid(dv[2]), .din_ready(rdy[2]),
      .sout(so[2]), .sout_valid(sv[2]), .last(lst[2]), .busy(bsy[2]));

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: a word waiting in the hold slot plus a list of upcoming output cycles.
   logic [W-1:0] m_hold [3];
   bit           m_hf   [3];
   bit           m_acc  [3];
   logic [2:0]   plan   [3][0:31];
   int           plen   [3];

   logic [W-1:0] pend [3][0:7];
   int           pcnt [3];
   int           pidx [3];
   bit           rnd = 1'b0;

   logic [3:0]   cap  [3][0:63];
   int           ncap [3];

   typedef struct {
      bit           dv;
      logic [W-1:0] din;
      logic [4:0]   exp;
   } vec_t;
   vec_t tbl [11];

   function automatic int gap_of(input int d);
      return (d == 1) ? 2 : 0;
   endfunction

   function automatic bit msb_of(input int d);
      return (d == 2) ? 1'b0 : 1'b1;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_edge(input int d);
      bit   pre;
      logic b;
      m_acc[d] = 1'b0;
      if (rst) begin
         plen[d] = 0;
         m_hf[d] = 1'b0;
         return;
      end
      pre = m_hf[d];
      if (plen[d] > 0) begin
         for (int i = 0; i < plen[d] - 1; i++) plan[d][i] = plan[d][i+1];
         plen[d] = plen[d] - 1;
      end
      if (plen[d] == 0 && pre) begin
         for (int i = 0; i < W; i++) begin
            b = msb_of(d) ? m_hold[d][W-1-i] : m_hold[d][i];
            plan[d][plen[d]] = {1'b1, b, (i == W - 1)};
            plen[d] = plen[d] + 1;
         end
         for (int g = 0; g < gap_of(d); g++) begin
            plan[d][plen[d]] = 3'b000;
            plen[d] = plen[d] + 1;
         end
         m_hf[d] = 1'b0;
      end
      if (dv[d] && !pre) begin
         m_hold[d] = din[d];
         m_hf[d]   = 1'b1;
         m_acc[d]  = 1'b1;
      end
   endtask

   task automatic drive_inputs();
      for (int d = 0; d < 3; d++) begin
         if (rnd) begin
            dv[d]  = ($urandom_range(0, 1) == 1);
            din[d] = W'($urandom);
         end else if (pidx[d] < pcnt[d]) begin
            dv[d]  = 1'b1;
            din[d] = pend[d][pidx[d]];
         end else begin
            dv[d]  = 1'b0;
            din[d] = W'($urandom);
         end
      end
   endtask

   task automatic step();
      logic [4:0] exp;
      @(posedge clock);
      for (int d = 0; d < 3; d++) model_edge(d);
      @(negedge clock);
      for (int d = 0; d < 3; d++) begin
         exp = {(plen[d] > 0) ? plan[d][0] : 3'b000, (plen[d] > 0) || m_hf[d], !m_hf[d]};
         check($sformatf("model_dut%0d", d), 32'({sv[d], so[d], lst[d], bsy[d], rdy[d]}), 32'(exp));
         if (ncap[d] < 64) begin
            cap[d][ncap[d]] = {sv[d], so[d], lst[d], rdy[d]};
            ncap[d] = ncap[d] + 1;
         end
         if (m_acc[d]) pidx[d] = pidx[d] + 1;
      end
      drive_inputs();
   endtask

   task automatic clear_all();
      for (int d = 0; d < 3; d++) begin
         pcnt[d] = 0;
         pidx[d] = 0;
         ncap[d] = 0;
      end
   endtask

   task automatic queue_word(input int d, input logic [W-1:0] w);
      pend[d][pcnt[d]] = w;
      pcnt[d] = pcnt[d] + 1;
   endtask

   // Checks an n-cycle window starting at the first valid cycle captured for instance d.
   task automatic analyze(input int d, input int n, input logic [31:0] ev,
                          input logic [31:0] eb, input logic [31:0] el, input string nm);
      int f;
      logic [31:0] v, b, l;
      f = -1;
      v = '0; b = '0; l = '0;
      for (int k = 0; k < ncap[d]; k++) if (f < 0 && cap[d][k][3]) f = k;
      check({nm, "_found"}, 32'(f >= 0), 32'd1);
      if (f < 0) return;
      for (int k = 0; k < n; k++) begin
         if (f + k < ncap[d]) begin
            v = {v[30:0], cap[d][f+k][3]};
            b = {b[30:0], cap[d][f+k][2]};
            l = {l[30:0], cap[d][f+k][1]};
         end else begin
            v = {v[30:0], 1'b0};
            b = {b[30:0], 1'b0};
            l = {l[30:0], 1'b0};
         end
      end
      check({nm, "_valid"}, v, ev);
      check({nm, "_bits"},  b, eb);
      check({nm, "_last"},  l, el);
      if (f + n < ncap[d]) check({nm, "_end"}, 32'(cap[d][f+n][3]), 32'd0);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 8'hB1, 5'b00010};
      tbl[1]  = '{1'b0, 8'h4E, 5'b11011};
      tbl[2]  = '{1'b0, 8'h00, 5'b10011};
      tbl[3]  = '{1'b0, 8'hFF, 5'b11011};
      tbl[4]  = '{1'b0, 8'h00, 5'b11011};
      tbl[5]  = '{1'b0, 8'h5A, 5'b10011};
      tbl[6]  = '{1'b0, 8'h00, 5'b10011};
      tbl[7]  = '{1'b0, 8'hC3, 5'b10011};
      tbl[8]  = '{1'b0, 8'h00, 5'b11111};
      tbl[9]  = '{1'b0, 8'h00, 5'b00001};
      tbl[10] = '{1'b0, 8'h00, 5'b00001};

      clear_all();
      for (int d = 0; d < 3; d++) begin
         plen[d] = 0;
         m_hf[d] = 1'b0;
         m_hold[d] = '0;
      end
      rst = 1'b1;
      drive_inputs();
      step();
      step();
      for (int d = 0; d < 3; d++)
         check($sformatf("reset_state_dut%0d", d), 32'({so[d], sv[d], lst[d], bsy[d]}), 32'd0);
      rst = 1'b0;
      step();
      for (int d = 0; d < 3; d++)
         check($sformatf("ready_after_reset_dut%0d", d), 32'(rdy[d]), 32'd1);

      // Single word, table-driven.
      for (int i = 0; i < 11; i++) begin
         dv[0]  = tbl[i].dv;
         din[0] = tbl[i].din;
         step();
         check($sformatf("table_b1_row%0d", i),
               32'({sv[0], so[0], lst[0], bsy[0], rdy[0]}), 32'(tbl[i].exp));
      end

      // Back-to-back on GAP=0.
      clear_all();
      queue_word(0, 8'hB1);
      queue_word(0, 8'h0F);
      drive_inputs();
      for (int i = 0; i < 40; i++) step();
      analyze(0, 16, 32'h0000FFFF, 32'(16'b1011000100001111), 32'(16'b0000000100000001), "b2b");

      // Backpressure with the producer holding valid continuously.
      clear_all();
      queue_word(0, 8'h3C);
      queue_word(0, 8'hA5);
      queue_word(0, 8'h5A);
      drive_inputs();
      for (int i = 0; i < 45; i++) step();
      analyze(0, 24, 32'h00FFFFFF, 32'(24'h3CA55A), 32'(24'b000000010000000100000001), "bp");
      check("bp_ready_low_while_b_held", 32'(cap[0][7][0]), 32'd0);
      check("bp_ready_back_when_b_loads", 32'(cap[0][9][0]), 32'd1);
      check("bp_ready_low_after_c", 32'(cap[0][10][0]), 32'd0);

      // GAP=2 instance.
      clear_all();
      queue_word(1, 8'hFF);
      queue_word(1, 8'h00);
      drive_inputs();
      for (int i = 0; i < 40; i++) step();
      analyze(1, 18, 32'(18'b111111110011111111), 32'(18'b111111110000000000),
              32'(18'b000000010000000001), "gap2");

      // LSB-first instance.
      clear_all();
      queue_word(2, 8'hB1);
      drive_inputs();
      for (int i = 0; i < 20; i++) step();
      analyze(2, 8, 32'h000000FF, 32'(8'b10001101), 32'(8'b00000001), "lsb");

      // Reset in the middle of streaming with more words waiting.
      clear_all();
      for (int d = 0; d < 3; d++) begin
         queue_word(d, 8'hC7);
         queue_word(d, 8'h96);
      end
      drive_inputs();
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      step();
      step();
      for (int d = 0; d < 3; d++)
         check($sformatf("midreset_dut%0d", d), 32'({so[d], sv[d], lst[d], bsy[d]}), 32'd0);
      clear_all();
      drive_inputs();
      rst = 1'b0;
      step();
      for (int d = 0; d < 3; d++)
         check($sformatf("midreset_ready_dut%0d", d), 32'(rdy[d]), 32'd1);
      for (int i = 0; i < 20; i++) step();
      for (int d = 0; d < 3; d++) begin
         int seen;
         seen = 0;
         for (int k = 0; k < ncap[d]; k++) if (cap[d][k][3]) seen++;
         check($sformatf("midreset_no_leftover_dut%0d", d), 32'(seen), 32'd0);
      end

      // Random traffic with occasional resets.
      rnd = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         step();
      end
      rst = 1'b0;
      rnd = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
